instruction_fetch: RTL and testbench
====================================

# instruction_fetch

IF stage of the MIPS pipeline: holds the program counter, an instruction memory filled byte-by-byte by the debug loader, and the IF/ID pipeline register that feeds `instruction_decode`. It is the producer end of the decode interface: it drives `o_instruction` and `o_pcounter4`, and it consumes stall and redirect (jump/branch) requests coming back from later stages. A halt word stops fetch.

## Interface
- `NB_DATA`, 32: instruction/PC width.
- `IMEM_DEPTH`, 256: instruction memory depth in words.
- `NB_IMEM_ADDR`, 8: word-index width, equal to log2(IMEM_DEPTH).
- `clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_enable`  in  1  pipeline run enable from the debug unit. 0 freezes PC, IF/ID and state.
- `i_stall`  in  1  hazard stall. Holds PC and IF/ID.
- `i_jump`  in  1  jump redirect request.
- `i_jump_addr`  in  NB_DATA  jump target, byte address.
- `i_branch_taken`  in  1  taken-branch redirect request.
- `i_branch_addr`  in  NB_DATA  branch target, byte address.
- `i_load_valid`  in  1  loader byte strobe.
- `i_load_byte`  in  8  loader byte. Big-endian: the first byte is instruction[31:24].
- `o_instruction`  out  NB_DATA  IF/ID instruction.
- `o_pcounter4`  out  NB_DATA  IF/ID PC+4.
- `o_pc`  out  NB_DATA  current PC.
- `o_load_words`  out  NB_IMEM_ADDR+1  count of words written since reset.
- `o_halt`  out  1  halt word has reached IF/ID.

## Operation
**States**
- LOAD, the reset state.
  - Each `i_load_valid` shifts `i_load_byte` into a 32-bit assembler.
  - A 2-bit byte counter tracks the bytes. On the 4th byte, the assembled word is written to `imem[wr_ptr]`, then `wr_ptr` and `o_load_words` increment.
  - `wr_ptr` wraps at IMEM_DEPTH. `o_load_words` saturates at IMEM_DEPTH.
- LOAD -> RUN on the first cycle with `i_enable`=1.
  - A partially assembled word is discarded.
  - In that same cycle, the first fetch from PC=0 occurs.
- RUN, when `i_enable`=1. Highest priority first:
  1. `i_branch_taken`: PC <= `i_branch_addr`; IF/ID <= NOP (0x00000000, pcounter4=0).
  2. `i_jump`: PC <= `i_jump_addr`; IF/ID <= NOP.
  3. `i_stall`: PC and IF/ID hold.
  4. Otherwise: IF/ID <= {imem[PC[NB_IMEM_ADDR+1:2]], PC+4}; PC <= PC+4.
- RUN -> HALT when the fetched word equals HALT_INSTR (0xFFFFFFFF) and it is captured into IF/ID.
  - PC is not incremented on that edge.
  - `o_halt` rises on the same edge.
- HALT holds PC and IF/ID. It is left only by reset. Redirects are ignored.

**Rules**
- In RUN and HALT, `i_load_valid` is ignored.
- When `i_enable`=0, nothing changes. This includes pending redirects, which are dropped and not queued.
- PC[1:0] is ignored for addressing. Index bits above NB_IMEM_ADDR+1 are truncated, so the fetch address wraps.
- PC+4 is modulo 2^32.
- Reset values:
  - PC = 0, `o_instruction` = 0, `o_pcounter4` = 0, `o_halt` = 0.
  - `o_load_words` = 0, `wr_ptr` = 0, byte counter = 0, state = LOAD.
- Memory contents are not reset.

## Timing
- Memory write is synchronous. Memory read is combinational from PC.
- Fetch latency is 1 cycle: the PC value at edge n appears in `o_instruction`/`o_pcounter4` after edge n.
- A redirect asserted before edge n:
  - the NOP is visible after edge n;
  - the target instruction is visible after edge n+1.
- Redirect and stall in the same cycle: the redirect wins.
- Branch and jump in the same cycle: the branch wins (older instruction).
- A loader word written at edge n is fetchable from edge n+1.
- An asynchronous reset mid-load or mid-run clears all registers immediately. Partial loader state is lost.

## Structure
- Shared package `mips_pkg` holds:
  - NB_DATA;
  - HALT_INSTR = 32'hFFFFFFFF;
  - NOP_INSTR = 32'h00000000;
  - the fetch state encoding (ST_LOAD, ST_RUN, ST_HALT).
- One sub-module, `instruction_memory`: a word array with a synchronous write port and a combinational read port, parameterized by IMEM_DEPTH.
- PC logic, loader assembler, FSM and the IF/ID register stay in the top level.

## Test plan
1. **Load and run.** Load 12 bytes for 0x00221821, 0x20220004, 0xFFFFFFFF, then assert `i_enable`.
   - `o_load_words`=3.
   - IF/ID shows {0x00221821, 4}, then {0x20220004, 8}, then 0xFFFFFFFF with `o_halt`=1.
   - PC stays 8.
2. **Stall.** Stall for 2 cycles after the first fetch.
   - `o_instruction` holds 0x00221821 and PC holds 4 for 2 cycles.
   - Fetch then resumes with 0x20220004.
3. **Jump.** `i_jump`=1 with `i_jump_addr`=0x10.
   - Next cycle: IF/ID={0,0}.
   - Following cycle: IF/ID={imem[4], 0x14}.
4. **Simultaneous requests.** Branch to 0x20, jump to 0x10 and stall all in one cycle.
   - PC=0x20 and IF/ID is the NOP.
5. **Enable and loader gating.** Drop `i_enable` for 3 cycles mid-run, then pulse `i_load_valid` in RUN.
   - All outputs are frozen.
   - `o_load_words` is unchanged.
6. **Reset mid-load.** Assert reset after 6 bytes.
   - All outputs are 0 and the state is LOAD.
   - Re-run without reloading: word 0 is still fetched correctly.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data width, special instruction words
// and the fetch-stage state encoding.
package mips_pkg;

  localparam int NB_DATA = 32;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Instruction word array: synchronous write from the loader, combinational
// read for the fetch path. Contents are deliberately not reset.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int NB_WORD    = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int NB_ADDR    = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_WORD-1:0] wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_WORD-1:0] rd_data
);

  logic [NB_WORD-1:0] mem_r [IMEM_DEPTH];

  // Loader write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, byte-wise debug loader into instruction memory, fetch
// FSM (LOAD/RUN/HALT) and the IF/ID pipeline register.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int IMEM_DEPTH   = 256,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_jump,
  input  logic [NB_DATA-1:0]      i_jump_addr,
  input  logic                    i_branch_taken,
  input  logic [NB_DATA-1:0]      i_branch_addr,
  input  logic                    i_load_valid,
  input  logic [7:0]              i_load_byte,
  output logic [NB_DATA-1:0]      o_instruction,
  output logic [NB_DATA-1:0]      o_pcounter4,
  output logic [NB_DATA-1:0]      o_pc,
  output logic [NB_IMEM_ADDR:0]   o_load_words,
  output logic                    o_halt
);

  localparam logic [NB_DATA-1:0]    PC_STEP        = NB_DATA'(32'd4);
  localparam logic [NB_IMEM_ADDR:0] LOAD_WORDS_MAX = (NB_IMEM_ADDR + 1)'(IMEM_DEPTH);

  fetch_state_t              state_r;
  fetch_state_t              state_next_s;
  logic [NB_DATA-1:0]        pc_r;
  logic [NB_DATA-1:0]        pc_next_s;
  logic [NB_DATA-1:0]        pc_plus4_s;
  logic [NB_DATA-1:0]        instr_r;
  logic [NB_DATA-1:0]        instr_next_s;
  logic [NB_DATA-1:0]        pc4_r;
  logic [NB_DATA-1:0]        pc4_next_s;
  logic                      halt_r;
  logic                      halt_next_s;
  logic [NB_DATA-1:0]        fetch_word_s;
  logic [NB_IMEM_ADDR-1:0]   wr_ptr_r;
  logic [NB_IMEM_ADDR:0]     load_words_r;
  logic [1:0]                byte_cnt_r;
  logic [23:0]               asm_r;
  logic                      load_accept_s;
  logic                      word_done_s;

  assign pc_plus4_s    = pc_r + PC_STEP;
  assign load_accept_s = (state_r == ST_LOAD) && !i_enable && i_load_valid;
  assign word_done_s   = load_accept_s && (byte_cnt_r == 2'd3);

  instruction_memory #(
    .NB_WORD    (NB_DATA),
    .IMEM_DEPTH (IMEM_DEPTH),
    .NB_ADDR    (NB_IMEM_ADDR)
  ) u_imem (
    .clk     (clk),
    .wr_en   (word_done_s),
    .wr_addr (wr_ptr_r),
    .wr_data ({asm_r, i_load_byte}),
    .rd_addr (pc_r[NB_IMEM_ADDR+1:2]),
    .rd_data (fetch_word_s)
  );

  // Next-state and IF/ID selection; redirects beat stall, branch beats jump
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    instr_next_s = instr_r;
    pc4_next_s   = pc4_r;
    halt_next_s  = halt_r;
    case (state_r)
      ST_LOAD, ST_RUN: begin
        if (i_enable) begin
          state_next_s = ST_RUN;
          if (i_branch_taken) begin
            pc_next_s    = i_branch_addr;
            instr_next_s = NOP_INSTR;
            pc4_next_s   = {NB_DATA{1'b0}};
          end else if (i_jump) begin
            pc_next_s    = i_jump_addr;
            instr_next_s = NOP_INSTR;
            pc4_next_s   = {NB_DATA{1'b0}};
          end else if (i_stall) begin
            pc_next_s    = pc_r;
          end else begin
            instr_next_s = fetch_word_s;
            pc4_next_s   = pc_plus4_s;
            if (fetch_word_s == HALT_INSTR) begin
              state_next_s = ST_HALT;
              halt_next_s  = 1'b1;
            end else begin
              pc_next_s    = pc_plus4_s;
            end
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_LOAD;
    endcase
  end

  // Fetch state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC and IF/ID pipeline register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_r    <= {NB_DATA{1'b0}};
      instr_r <= {NB_DATA{1'b0}};
      pc4_r   <= {NB_DATA{1'b0}};
      halt_r  <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      instr_r <= instr_next_s;
      pc4_r   <= pc4_next_s;
      halt_r  <= halt_next_s;
    end
  end

  // Big-endian byte assembler; leaving LOAD drops any partial word
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      asm_r        <= 24'd0;
      byte_cnt_r   <= 2'd0;
      wr_ptr_r     <= {NB_IMEM_ADDR{1'b0}};
      load_words_r <= {(NB_IMEM_ADDR + 1){1'b0}};
    end else if (load_accept_s) begin
      asm_r      <= {asm_r[15:0], i_load_byte};
      byte_cnt_r <= byte_cnt_r + 2'd1;
      if (word_done_s) begin
        wr_ptr_r <= wr_ptr_r + {{(NB_IMEM_ADDR - 1){1'b0}}, 1'b1};
        if (load_words_r != LOAD_WORDS_MAX) begin
          load_words_r <= load_words_r + {{NB_IMEM_ADDR{1'b0}}, 1'b1};
        end
      end
    end else if ((state_r == ST_LOAD) && i_enable) begin
      asm_r      <= 24'd0;
      byte_cnt_r <= 2'd0;
    end
  end

  assign o_instruction = instr_r;
  assign o_pcounter4   = pc4_r;
  assign o_pc          = pc_r;
  assign o_load_words  = load_words_r;
  assign o_halt        = halt_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_instruction_fetch;

  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int DEPTH  = 256;

  localparam logic [31:0] W0 = 32'h0022_1821;
  localparam logic [31:0] W1 = 32'h2022_0004;
  localparam logic [31:0] WH = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst_n, i_enable, i_stall, i_jump, i_branch_taken, i_load_valid;
  logic [31:0] i_jump_addr, i_branch_addr;
  logic [7:0]  i_load_byte;
  logic [31:0] o_instruction, o_pcounter4, o_pc;
  logic [8:0]  o_load_words;
  logic        o_halt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_stall(i_stall),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_branch_taken(i_branch_taken),
    .i_branch_addr(i_branch_addr), .i_load_valid(i_load_valid), .i_load_byte(i_load_byte),
    .o_instruction(o_instruction), .o_pcounter4(o_pcounter4), .o_pc(o_pc),
    .o_load_words(o_load_words), .o_halt(o_halt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          st;
    logic [31:0] pc, instr, pc4;
    logic        halt;
    int          words, wptr, nbytes;
    logic [31:0] acc;
  } model_t;

  model_t      m, nx;
  logic [31:0] m_mem [DEPTH];
  logic        m_wr;
  int          m_wa;
  logic [31:0] m_wd;

  always_comb begin
    nx   = m;
    m_wr = 1'b0;
    m_wa = 0;
    m_wd = 32'd0;
    if (m.st == M_LOAD && !i_enable && i_load_valid) begin
      nx.acc    = (m.acc << 8) | {24'd0, i_load_byte};
      nx.nbytes = m.nbytes + 1;
      if (nx.nbytes == 4) begin
        m_wr      = 1'b1;
        m_wa      = m.wptr;
        m_wd      = nx.acc;
        nx.wptr   = (m.wptr + 1) % DEPTH;
        nx.words  = (m.words < DEPTH) ? m.words + 1 : DEPTH;
        nx.nbytes = 0;
      end
    end
    if (m.st != M_HALT && i_enable) begin
      nx.st     = M_RUN;
      nx.nbytes = 0;
      if (i_branch_taken) begin
        nx.pc = i_branch_addr; nx.instr = 32'd0; nx.pc4 = 32'd0;
      end else if (i_jump) begin
        nx.pc = i_jump_addr;   nx.instr = 32'd0; nx.pc4 = 32'd0;
      end else if (!i_stall) begin
        nx.instr = m_mem[8'((m.pc >> 2) % 32'd256)];
        nx.pc4   = m.pc + 32'd4;
        if (nx.instr == WH) begin
          nx.st   = M_HALT;
          nx.halt = 1'b1;
        end else begin
          nx.pc   = m.pc + 32'd4;
        end
      end
    end
  end

  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m.st <= M_LOAD; m.pc <= 32'd0; m.instr <= 32'd0; m.pc4 <= 32'd0; m.halt <= 1'b0;
      m.words <= 0; m.wptr <= 0; m.nbytes <= 0; m.acc <= 32'd0;
    end else begin
      m <= nx;
      if (m_wr) m_mem[m_wa] <= m_wd;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("pc", o_pc, m.pc);
    check("instruction", o_instruction, m.instr);
    check("pcounter4", o_pcounter4, m.pc4);
    check("halt", {31'd0, o_halt}, {31'd0, m.halt});
    check("load_words", {23'd0, o_load_words}, 32'(m.words));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_req();
    i_stall = 1'b0; i_jump = 1'b0; i_branch_taken = 1'b0; i_load_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check("rst_pc", o_pc, 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_pc4", o_pcounter4, 32'd0);
    check("rst_halt", {31'd0, o_halt}, 32'd0);
    check("rst_load_words", {23'd0, o_load_words}, 32'd0);
    i_rst_n = 1'b1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    step();
    i_load_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) load_byte(w[31-8*b -: 8]);
  endtask

  task automatic expect_ifid(input string name, input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] pc);
    check({name, "_instr"}, o_instruction, ins);
    check({name, "_pc4"}, o_pcounter4, p4);
    check({name, "_pc"}, o_pc, pc);
  endtask

  initial begin
    i_rst_n = 1'b0; i_enable = 1'b0; i_jump_addr = 32'd0; i_branch_addr = 32'd0;
    i_load_byte = 8'd0;
    clear_req();
    step();
    do_reset();

    // Load and run to halt
    load_word(W0); load_word(W1); load_word(WH);
    check("a_load_words", {23'd0, o_load_words}, 32'd3);
    i_enable = 1'b1;
    step(); expect_ifid("a1", W0, 32'd4, 32'd4);
    step(); expect_ifid("a2", W1, 32'd8, 32'd8);
    step(); expect_ifid("a3", WH, 32'd12, 32'd8);
    check("a3_halt", {31'd0, o_halt}, 32'd1);
    step(); check("a4_pc_held", o_pc, 32'd8);

    // Stall after first fetch
    i_enable = 1'b0;
    do_reset();
    i_enable = 1'b1;
    step(); expect_ifid("b1", W0, 32'd4, 32'd4);
    i_stall = 1'b1;
    step(); expect_ifid("b2", W0, 32'd4, 32'd4);
    step(); expect_ifid("b3", W0, 32'd4, 32'd4);
    i_stall = 1'b0;
    step(); expect_ifid("b4", W1, 32'd8, 32'd8);

    // Jump, enable gating, simultaneous requests, halt ignores redirects
    i_enable = 1'b0;
    do_reset();
    load_word(W0); load_word(W1); load_word(32'h8C01_0000); load_word(32'hAC01_0004);
    load_word(32'h1021_0003); load_word(32'h0800_0002); load_word(32'h0000_0020);
    load_word(32'h0000_0024); load_word(WH);
    check("c_load_words", {23'd0, o_load_words}, 32'd9);
    i_enable = 1'b1;
    step(); expect_ifid("c1", W0, 32'd4, 32'd4);
    i_jump = 1'b1; i_jump_addr = 32'h10;
    step(); expect_ifid("c_jump_nop", 32'd0, 32'd0, 32'h10);
    i_jump = 1'b0;
    step(); expect_ifid("c_jump_tgt", 32'h1021_0003, 32'h14, 32'h14);
    step(); expect_ifid("c4", 32'h0800_0002, 32'h18, 32'h18);
    i_enable = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h4; i_load_valid = 1'b1; i_load_byte = 8'h55;
    repeat (3) step();
    expect_ifid("c_frozen", 32'h0800_0002, 32'h18, 32'h18);
    check("c_frozen_words", {23'd0, o_load_words}, 32'd9);
    i_enable = 1'b1; i_jump = 1'b0;
    step(); expect_ifid("c_resume", 32'h0000_0020, 32'h1C, 32'h1C);
    check("c_run_load_ignored", {23'd0, o_load_words}, 32'd9);
    i_load_valid = 1'b0;
    i_branch_taken = 1'b1; i_branch_addr = 32'h20; i_jump = 1'b1; i_jump_addr = 32'h10; i_stall = 1'b1;
    step(); expect_ifid("c_simul", 32'd0, 32'd0, 32'h20);
    clear_req();
    step(); expect_ifid("c_halt", WH, 32'h24, 32'h20);
    check("c_halt_flag", {31'd0, o_halt}, 32'd1);
    i_jump = 1'b1; i_jump_addr = 32'h4; i_branch_taken = 1'b1;
    step(); step();
    expect_ifid("c_halt_hold", WH, 32'h24, 32'h20);
    clear_req();

    // Reset mid-load; earlier memory contents survive
    i_enable = 1'b0;
    do_reset();
    load_word(W0); load_byte(8'hAA); load_byte(8'hBB);
    check("d_words_before", {23'd0, o_load_words}, 32'd1);
    do_reset();
    i_enable = 1'b1;
    step(); expect_ifid("d1", W0, 32'd4, 32'd4);
    step(); expect_ifid("d2", W1, 32'd8, 32'd8);

    // Write-pointer wrap, count saturation, fetch-index wrap, PC+4 rollover
    i_enable = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word({24'd0, 8'(i)});
    check("e_words_full", {23'd0, o_load_words}, 32'd256);
    load_word(32'h1234_5678);
    check("e_words_sat", {23'd0, o_load_words}, 32'd256);
    i_enable = 1'b1;
    step(); expect_ifid("e1", 32'h1234_5678, 32'd4, 32'd4);
    i_jump = 1'b1; i_jump_addr = 32'h403;
    step(); i_jump = 1'b0;
    step(); expect_ifid("e_idx_wrap", 32'h1234_5678, 32'h407, 32'h407);
    i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFC;
    step(); i_jump = 1'b0;
    step(); expect_ifid("e_pc_roll", 32'h0000_00FF, 32'd0, 32'd0);
    step(); expect_ifid("e_after_roll", 32'h1234_5678, 32'd4, 32'd4);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
